// File: rtl/axi_log_ctrl.sv
// ---------------------------------------------------------------------------
// axi_log_ctrl
// Run controller shared by the AR and AW BRAM loggers. Software commands
// (START / STOP / CLEAR) become a logging-enable level and a timed clear
// pulse. Logging stops by itself when either logger reports nearly-full.
// A sticky interrupt flags that event, and a saturating counter records
// how many cycles were spent logging.
//
// Ports
//   Clk_CI        : clock
//   Rst_RBI       : asynchronous active-low reset
//   CmdValid_SI   : command valid
//   CmdReady_SO   : command ready (low only while clearing)
//   Cmd_DI        : 00 NOP, 01 START, 10 STOP, 11 CLEAR
//   ArFull_SI     : AR logger nearly-full
//   AwFull_SI     : AW logger nearly-full
//   LogEn_SO      : logging enable to both loggers
//   Clear_SO      : clear to both loggers
//   IrqFull_SO    : sticky full interrupt
//   IrqAck_SI     : interrupt acknowledge (single cycle)
//   State_SO      : current FSM state (0 IDLE, 1 LOGGING, 2 FULL, 3 CLEARING)
//   LogCycles_DO  : saturating count of cycles spent in LOGGING
// ---------------------------------------------------------------------------
module axi_log_ctrl #(
   parameter int unsigned CLEAR_CYCLES = 4,   // legal range 1..255
   parameter int unsigned CNT_BITW     = 32
) (
   input  logic                Clk_CI,
   input  logic                Rst_RBI,
   input  logic                CmdValid_SI,
   output logic                CmdReady_SO,
   input  logic [1:0]          Cmd_DI,
   input  logic                ArFull_SI,
   input  logic                AwFull_SI,
   output logic                LogEn_SO,
   output logic                Clear_SO,
   output logic                IrqFull_SO,
   input  logic                IrqAck_SI,
   output logic [1:0]          State_SO,
   output logic [CNT_BITW-1:0] LogCycles_DO
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOGGING  = 2'd1,
      FULL     = 2'd2,
      CLEARING = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'b00,
      CMD_START = 2'b01,
      CMD_STOP  = 2'b10,
      CMD_CLEAR = 2'b11
   } cmd_e;

   localparam logic [7:0]          CLR_LOAD = 8'(CLEAR_CYCLES);
   localparam logic [CNT_BITW-1:0] CNT_ONE  = CNT_BITW'(1);
   localparam logic [CNT_BITW-1:0] CNT_MAX  = '1;

   state_e              state_q, state_d;
   logic [7:0]          clr_cnt_q, clr_cnt_d;
   logic                irq_q, irq_d;
   logic [CNT_BITW-1:0] cnt_q, cnt_d;

   logic cmd_acc;
   logic any_full;
   logic cmd_start, cmd_stop, cmd_clear;

   assign any_full  = ArFull_SI | AwFull_SI;
   assign cmd_acc   = CmdValid_SI & CmdReady_SO;
   assign cmd_start = cmd_acc & (cmd_e'(Cmd_DI) == CMD_START);
   assign cmd_stop  = cmd_acc & (cmd_e'(Cmd_DI) == CMD_STOP);
   assign cmd_clear = cmd_acc & (cmd_e'(Cmd_DI) == CMD_CLEAR);

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   // NOTE: non-blocking assignments keep every register sampling the
   // pre-edge values, independent of statement order.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_q   <= IDLE;
         clr_cnt_q <= '0;
         irq_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         irq_q     <= irq_d;
         cnt_q     <= cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_start)      state_d = LOGGING;
            else if (cmd_clear) state_d = CLEARING;
         end
         LOGGING: begin
            // An accepted STOP/CLEAR wins over a simultaneous full.
            if (cmd_stop)       state_d = IDLE;
            else if (cmd_clear) state_d = CLEARING;
            else if (any_full)  state_d = FULL;
         end
         FULL: begin
            // START is ignored here: the loggers must be cleared first.
            if (cmd_stop)       state_d = IDLE;
            else if (cmd_clear) state_d = CLEARING;
         end
         CLEARING: begin
            if (clr_cnt_q <= 8'd1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Clear timer, interrupt flag and cycle counter.
   always_comb begin
      clr_cnt_d = clr_cnt_q;
      if ((state_d == CLEARING) && (state_q != CLEARING)) begin
         clr_cnt_d = CLR_LOAD;
      end else if ((state_q == CLEARING) && (clr_cnt_q != 8'd0)) begin
         clr_cnt_d = clr_cnt_q - 8'd1;
      end

      // Set beats acknowledge in the same cycle.
      irq_d = irq_q;
      if ((state_q == LOGGING) && any_full) begin
         irq_d = 1'b1;
      end else if (IrqAck_SI || (state_q == CLEARING)) begin
         irq_d = 1'b0;
      end

      cnt_d = cnt_q;
      if (state_q == CLEARING) begin
         cnt_d = '0;
      end else if ((state_q == LOGGING) && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // -------------------------------------------------------------------------
   // Moore outputs
   // -------------------------------------------------------------------------
   always_comb begin
      LogEn_SO     = (state_q == LOGGING);
      Clear_SO     = (state_q == CLEARING);
      CmdReady_SO  = (state_q != CLEARING);
      State_SO     = state_q;
      IrqFull_SO   = irq_q;
      LogCycles_DO = cnt_q;
   end

endmodule

// File: tb/tb_axi_log_ctrl.sv
module tb_axi_log_ctrl;

   localparam int CLR_CYC = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic       ar_full = 1'b0;
   logic       aw_full = 1'b0;
   logic       ack = 1'b0;

   // Wide-counter instance (default width)
   logic        a_ready, a_log_en, a_clear, a_irq;
   logic [1:0]  a_state;
   logic [31:0] a_cycles;
   // Narrow-counter instance for saturation
   logic        b_ready, b_log_en, b_clear, b_irq;
   logic [1:0]  b_state;
   logic [3:0]  b_cycles;

   int checks = 0;
   int errors = 0;

   axi_log_ctrl #(.CLEAR_CYCLES(CLR_CYC), .CNT_BITW(32)) dut_a (
      .Clk_CI(clk), .Rst_RBI(rst_n),
      .CmdValid_SI(valid), .CmdReady_SO(a_ready), .Cmd_DI(cmd),
      .ArFull_SI(ar_full), .AwFull_SI(aw_full),
      .LogEn_SO(a_log_en), .Clear_SO(a_clear), .IrqFull_SO(a_irq),
      .IrqAck_SI(ack), .State_SO(a_state), .LogCycles_DO(a_cycles)
   );

   axi_log_ctrl #(.CLEAR_CYCLES(CLR_CYC), .CNT_BITW(4)) dut_b (
      .Clk_CI(clk), .Rst_RBI(rst_n),
      .CmdValid_SI(valid), .CmdReady_SO(b_ready), .Cmd_DI(cmd),
      .ArFull_SI(ar_full), .AwFull_SI(aw_full),
      .LogEn_SO(b_log_en), .Clear_SO(b_clear), .IrqFull_SO(b_irq),
      .IrqAck_SI(ack), .State_SO(b_state), .LogCycles_DO(b_cycles)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model: mode name, remaining clear cycles, flag, and the
   // unbounded number of logging cycles (saturation applied on compare).
   // ------------------------------------------------------------------
   localparam int M_IDLE = 0, M_LOG = 1, M_FULL = 2, M_CLR = 3;
   int m_mode;
   int m_clr_left;
   int m_logged;
   bit m_irq;

   function automatic logic [63:0] sat(input int n, input int w);
      longint mx;
      mx = (64'sd1 <<< w) - 1;
      return (longint'(n) > mx) ? 64'(mx) : 64'(n);
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_clr_left = 0; m_logged = 0; m_irq = 1'b0;
   endtask

   // Apply one rising edge to the model using the inputs now applied.
   task automatic model_step();
      bit full, acc;
      int nxt;
      full = ar_full | aw_full;
      acc  = valid && (m_mode != M_CLR);
      nxt  = m_mode;
      if (m_mode == M_LOG && full)            m_irq = 1'b1;
      else if (ack || m_mode == M_CLR)        m_irq = 1'b0;
      if (m_mode == M_LOG)                    m_logged = m_logged + 1;
      if (m_mode == M_CLR)                    m_logged = 0;
      if (m_mode == M_CLR) begin
         m_clr_left = m_clr_left - 1;
         if (m_clr_left == 0) nxt = M_IDLE;
      end else if (acc && cmd == 2'b11) begin
         nxt = M_CLR;
         m_clr_left = CLR_CYC;
      end else if (acc && cmd == 2'b10) begin
         nxt = M_IDLE;
      end else if (acc && cmd == 2'b01 && m_mode == M_IDLE) begin
         nxt = M_LOG;
      end else if (m_mode == M_LOG && full) begin
         nxt = M_FULL;
      end
      m_mode = nxt;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".a_state"}, 64'(a_state), 64'(m_mode));
      check({tag, ".a_log_en"}, 64'(a_log_en), 64'(m_mode == M_LOG));
      check({tag, ".a_clear"}, 64'(a_clear), 64'(m_mode == M_CLR));
      check({tag, ".a_ready"}, 64'(a_ready), 64'(m_mode != M_CLR));
      check({tag, ".a_irq"}, 64'(a_irq), 64'(m_irq));
      check({tag, ".a_cycles"}, 64'(a_cycles), sat(m_logged, 32));
      check({tag, ".b_state"}, 64'(b_state), 64'(m_mode));
      check({tag, ".b_irq"}, 64'(b_irq), 64'(m_irq));
      check({tag, ".b_cycles"}, 64'(b_cycles), sat(m_logged, 4));
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic drive(input logic v, input logic [1:0] c);
      valid = v; cmd = c;
   endtask

   int clr_high;

   initial begin
      // ---------------- reset ----------------
      model_reset();
      #12;
      compare_all("reset");
      check("reset.ready", 64'(a_ready), 64'd1);
      check("reset.cycles", 64'(a_cycles), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick("idle");

      // ---------------- start / stop, 10 logging cycles ----------------
      drive(1'b1, 2'b01);
      tick("start");
      drive(1'b0, 2'b00);
      check("start.log_en", 64'(a_log_en), 64'd1);
      repeat (9) tick("logging");
      drive(1'b1, 2'b10);
      tick("stop");
      drive(1'b0, 2'b00);
      check("stop.cycles", 64'(a_cycles), 64'd10);
      check("stop.state", 64'(a_state), 64'd0);
      check("stop.log_en", 64'(a_log_en), 64'd0);

      // ---------------- auto-stop on full ----------------
      drive(1'b1, 2'b01);
      tick("start2");
      drive(1'b0, 2'b00);
      aw_full = 1'b1;
      tick("awfull");
      aw_full = 1'b0;
      check("awfull.state", 64'(a_state), 64'd2);
      check("awfull.log_en", 64'(a_log_en), 64'd0);
      check("awfull.irq", 64'(a_irq), 64'd1);
      drive(1'b1, 2'b01);
      tick("start_in_full");
      drive(1'b0, 2'b00);
      check("start_in_full.state", 64'(a_state), 64'd2);
      ack = 1'b1;
      tick("ack");
      ack = 1'b0;
      check("ack.irq", 64'(a_irq), 64'd0);

      // ---------------- clear sequencing with START held ----------------
      drive(1'b1, 2'b11);
      tick("clear");
      cmd = 2'b01;
      clr_high = (a_clear === 1'b1 && a_ready === 1'b0) ? 1 : 0;
      repeat (3) begin
         tick("clearing");
         if (a_clear === 1'b1 && a_ready === 1'b0) clr_high++;
      end
      tick("clear_exit");
      check("clear.high_cycles", 64'(clr_high), 64'd4);
      check("clear_exit.clear", 64'(a_clear), 64'd0);
      check("clear_exit.cycles", 64'(a_cycles), 64'd0);
      check("clear_exit.irq", 64'(a_irq), 64'd0);
      tick("held_start");
      drive(1'b0, 2'b00);
      check("held_start.state", 64'(a_state), 64'd1);

      // ---------------- simultaneous STOP + full ----------------
      drive(1'b1, 2'b10);
      ar_full = 1'b1;
      tick("stop_full");
      drive(1'b0, 2'b00);
      ar_full = 1'b0;
      check("stop_full.state", 64'(a_state), 64'd0);
      check("stop_full.irq", 64'(a_irq), 64'd1);
      ack = 1'b1;
      tick("ack2");
      ack = 1'b0;
      drive(1'b1, 2'b01);
      tick("start3");
      drive(1'b0, 2'b00);
      ar_full = 1'b1;
      ack = 1'b1;
      tick("set_vs_ack");
      ar_full = 1'b0;
      ack = 1'b0;
      check("set_vs_ack.irq", 64'(a_irq), 64'd1);

      // ---------------- saturation ----------------
      drive(1'b1, 2'b11);
      tick("clear2");
      drive(1'b0, 2'b00);
      repeat (CLR_CYC) tick("clearing2");
      drive(1'b1, 2'b01);
      tick("start4");
      drive(1'b0, 2'b00);
      repeat (19) tick("logging_sat");
      drive(1'b1, 2'b10);
      tick("stop_sat");
      drive(1'b0, 2'b00);
      check("sat.b_cycles", 64'(b_cycles), 64'd15);
      check("sat.a_cycles", 64'(a_cycles), 64'd20);

      // ---------------- async reset during clearing ----------------
      drive(1'b1, 2'b11);
      tick("clear3");
      drive(1'b0, 2'b00);
      tick("clear3_c2");
      check("clear3_c2.clear", 64'(a_clear), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid.a_clear", 64'(a_clear), 64'd0);
      check("rst_mid.b_clear", 64'(b_clear), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick("after_rst");
      check("after_rst.state", 64'(a_state), 64'd0);
      check("after_rst.ready", 64'(a_ready), 64'd1);

      // ---------------- randomized traffic ----------------
      for (int i = 0; i < 400; i++) begin
         valid   = ($urandom_range(0, 2) != 0);
         cmd     = 2'($urandom_range(0, 3));
         ar_full = ($urandom_range(0, 9) == 0);
         aw_full = ($urandom_range(0, 9) == 0);
         ack     = ($urandom_range(0, 5) == 0);
         tick("random");
      end
      drive(1'b0, 2'b00);
      ar_full = 1'b0; aw_full = 1'b0; ack = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
